// File: rtl/psum_acc_if.sv
// rtl/psum_acc_if.sv - psum input stream and drained-sum output stream of psum_acc
interface psum_acc_if #(
    parameter int BIT_WIDTH = 9,
    parameter int ACC_WIDTH = 24
) ();
    logic [2*BIT_WIDTH-1:0] i_psum;
    logic                   i_psum_vld;
    logic [ACC_WIDTH-1:0]   o_data;
    logic                   o_vld;
    logic                   i_rdy;

    // environment side: produces psums, consumes drained sums
    modport master (
        output i_psum, i_psum_vld, i_rdy,
        input  o_data, o_vld
    );

    // collector side
    modport slave (
        input  i_psum, i_psum_vld, i_rdy,
        output o_data, o_vld
    );
endinterface

// File: rtl/psum_acc.sv
// rtl/psum_acc.sv - multi-pass partial-sum collector with valid/ready drain
module psum_acc #(
    parameter int BIT_WIDTH = 9,
    parameter int ACC_WIDTH = 24,
    parameter int DEPTH     = 64,
    parameter int PASS_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [$clog2(DEPTH):0] i_num_pix,
    input  logic [PASS_W-1:0]      i_num_pass,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    psum_acc_if.slave              bus
);

    localparam int PIX_W  = $clog2(DEPTH) + 1;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PIX_W-1:0] DEPTH_P = PIX_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [PIX_W-1:0]     pix_cnt_q,  pix_cnt_d;
    logic [PASS_W-1:0]    pass_cnt_q, pass_cnt_d;
    logic [PIX_W-1:0]     num_pix_q,  num_pix_d;
    logic [PASS_W-1:0]    num_pass_q, num_pass_d;
    logic [ACC_WIDTH-1:0] data_q,     data_d;
    logic                 vld_q,      vld_d;
    logic                 done_q,     done_d;
    logic                 err_q,      err_d;

    // tile buffer; contents are don't-care until written in pass 0
    logic [ACC_WIDTH-1:0] mem_q [DEPTH];
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_waddr;
    logic [ACC_WIDTH-1:0] mem_wdata;
    logic [ACC_WIDTH-1:0] mem_rdata;

    logic                 cfg_ok;
    logic                 last_pix;
    logic                 last_pass;
    logic                 beat_xfer;
    logic                 beat_last;
    logic [ACC_WIDTH-1:0] psum_ext;

    // pix_cnt serves as write pointer in ACCUM and as read pointer in DRAIN
    assign mem_rdata = mem_q[pix_cnt_q[ADDR_W-1:0]];
    assign psum_ext  = ACC_WIDTH'($signed(bus.i_psum));

    assign cfg_ok    = (i_num_pix != '0) && (i_num_pix <= DEPTH_P) && (i_num_pass != '0);
    assign last_pix  = (pix_cnt_q == num_pix_q - 1'b1);
    assign last_pass = (pass_cnt_q == num_pass_q - 1'b1);
    assign beat_xfer = vld_q && bus.i_rdy;
    // pix_cnt already points past the last entry once the final beat is loaded
    assign beat_last = beat_xfer && (pix_cnt_q == num_pix_q);

    // state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start && cfg_ok) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (bus.i_psum_vld && last_pix && last_pass) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (beat_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // datapath and registered-output next values per state
    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        pass_cnt_d = pass_cnt_q;
        num_pix_d  = num_pix_q;
        num_pass_d = num_pass_q;
        data_d     = data_q;
        vld_d      = vld_q;
        done_d     = 1'b0;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_waddr  = pix_cnt_q[ADDR_W-1:0];
        mem_wdata  = psum_ext;

        case (state_q)
            ST_IDLE: begin
                vld_d = 1'b0;
                if (i_start) begin
                    if (cfg_ok) begin
                        num_pix_d  = i_num_pix;
                        num_pass_d = i_num_pass;
                        pix_cnt_d  = '0;
                        pass_cnt_d = '0;
                        err_d      = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // a stray psum is reported even if a start arrives alongside it
                if (bus.i_psum_vld) begin
                    err_d = 1'b1;
                end
            end

            ST_ACCUM: begin
                if (bus.i_psum_vld) begin
                    mem_we = 1'b1;
                    // first pass overwrites, so no residue from an earlier tile
                    mem_wdata = (pass_cnt_q == '0) ? psum_ext : (mem_rdata + psum_ext);
                    if (last_pix) begin
                        pix_cnt_d  = '0;
                        pass_cnt_d = last_pass ? '0 : (pass_cnt_q + 1'b1);
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                if (bus.i_psum_vld) begin
                    err_d = 1'b1;
                end
                // refill the output register whenever it is empty or being consumed
                if (!vld_q || bus.i_rdy) begin
                    if (pix_cnt_q != num_pix_q) begin
                        data_d    = mem_rdata;
                        vld_d     = 1'b1;
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end else begin
                        vld_d = 1'b0;
                    end
                end
                if (beat_last) begin
                    done_d    = 1'b1;
                    pix_cnt_d = '0;
                end
            end

            default: begin
                vld_d = 1'b0;
            end
        endcase
    end

    // datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_cnt_q  <= '0;
            pass_cnt_q <= '0;
            num_pix_q  <= '0;
            num_pass_q <= '0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            num_pix_q  <= num_pix_d;
            num_pass_q <= num_pass_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // buffer write port; read-modify-write lands at the accepting edge
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.o_data = data_q;
    assign bus.o_vld  = vld_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_psum_acc.sv
// tb/tb_psum_acc.sv - directed self-checking bench for psum_acc
module tb_psum_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic [6:0] i_num_pix;
    logic [7:0] i_num_pass;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_mem [64];
    int          first_cyc;
    int          last_cyc;

    always #5 clk = ~clk;

    psum_acc_if #(.BIT_WIDTH(9), .ACC_WIDTH(24)) bus ();

    psum_acc #(
        .BIT_WIDTH(9),
        .ACC_WIDTH(24),
        .DEPTH(64),
        .PASS_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_num_pix (i_num_pix),
        .i_num_pass(i_num_pass),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err),
        .bus       (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, {8'h0, bus.o_data}, 32'h0);
        chk({tag, "_vld"},  {31'h0, bus.o_vld}, 32'h0);
        chk({tag, "_busy"}, {31'h0, o_busy},    32'h0);
        chk({tag, "_done"}, {31'h0, o_done},    32'h0);
        chk({tag, "_err"},  {31'h0, o_err},     32'h0);
    endtask

    task automatic start_tile(input int np, input int npass);
        i_num_pix  = 7'(np);
        i_num_pass = 8'(npass);
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
    endtask

    task automatic send(input int v);
        bus.i_psum     = 18'(v);
        bus.i_psum_vld = 1'b1;
        tick();
        bus.i_psum_vld = 1'b0;
    endtask

    // mode 0: i_rdy always high; mode 1: i_rdy follows 1,0,0,1,0,1 repeating
    task automatic drain(input int n, input int mode);
        int          idx = 0;
        int          cyc = 0;
        logic        held = 1'b0;
        logic [23:0] hv = '0;
        logic [5:0]  pat = 6'b101001;
        first_cyc = -1;
        last_cyc  = -1;
        while (idx < n && cyc < 400) begin
            bus.i_rdy = (mode == 0) ? 1'b1 : pat[cyc % 6];
            if (held) chk("hold_stable", {8'h0, bus.o_data}, {8'h0, hv});
            chk("done_early", {31'h0, o_done}, 32'h0);
            held = bus.o_vld && !bus.i_rdy;
            hv   = bus.o_data;
            if (bus.o_vld && bus.i_rdy) begin
                chk($sformatf("beat%0d", idx), {8'h0, bus.o_data}, {8'h0, exp_mem[idx]});
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                idx++;
            end
            tick();
            cyc++;
        end
        bus.i_rdy = 1'b0;
        chk("drain_count", idx, n);
        chk("done_pulse",  {31'h0, o_done},    32'h1);
        chk("vld_after",   {31'h0, bus.o_vld}, 32'h0);
        chk("busy_after",  {31'h0, o_busy},    32'h0);
        tick();
        chk("done_once",   {31'h0, o_done},    32'h0);
    endtask

    initial begin
        rst            = 1'b0;
        i_start        = 1'b0;
        i_num_pix      = '0;
        i_num_pass     = '0;
        bus.i_psum     = '0;
        bus.i_psum_vld = 1'b0;
        bus.i_rdy      = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // basic single pass, back-to-back psums, latency and no bubbles
        start_tile(4, 1);
        chk("basic_busy", {31'h0, o_busy}, 32'h1);
        send(1); send(2); send(3); send(4);
        chk("basic_vld_t1", {31'h0, bus.o_vld}, 32'h0);
        exp_mem[0] = 24'd1; exp_mem[1] = 24'd2; exp_mem[2] = 24'd3; exp_mem[3] = 24'd4;
        drain(4, 0);
        chk("basic_first_lat", first_cyc, 1);
        chk("basic_no_bubble", last_cyc - first_cyc, 3);

        // multi-pass signed; a start during ACCUM must be ignored
        start_tile(2, 3);
        send(5); send(-1);
        i_num_pix  = 7'd1;
        i_num_pass = 8'd1;
        i_start    = 1'b1;
        send(5);
        i_start    = 1'b0;
        send(-1);
        send(-20); send(2);
        exp_mem[0] = 24'hFFFFF6; exp_mem[1] = 24'h000000;
        drain(2, 0);
        chk("mp_err", {31'h0, o_err}, 32'h0);

        // backpressure with a toggling ready
        start_tile(3, 1);
        send(10); send(20); send(30);
        exp_mem[0] = 24'd10; exp_mem[1] = 24'd20; exp_mem[2] = 24'd30;
        drain(3, 1);

        // one pixel, four passes: each update must see the previous one
        start_tile(1, 4);
        send(7); send(7); send(7); send(7);
        exp_mem[0] = 24'd28;
        drain(1, 0);

        // full depth, two passes
        start_tile(64, 2);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 64; k++) send(k);
        end
        for (int k = 0; k < 64; k++) exp_mem[k] = 24'(2 * k);
        drain(64, 0);

        // illegal configurations
        start_tile(0, 1);
        chk("err_np0",       {31'h0, o_err},  32'h1);
        chk("err_np0_busy",  {31'h0, o_busy}, 32'h0);
        start_tile(65, 1);
        chk("err_np65",      {31'h0, o_err},  32'h1);
        chk("err_np65_busy", {31'h0, o_busy}, 32'h0);
        start_tile(2, 0);
        chk("err_npass0",    {31'h0, o_err},  32'h1);
        start_tile(2, 1);
        chk("err_cleared",   {31'h0, o_err},  32'h0);
        chk("err_clr_busy",  {31'h0, o_busy}, 32'h1);
        send(3); send(4);
        // stray psum while draining
        bus.i_psum     = 18'd100;
        bus.i_psum_vld = 1'b1;
        tick();
        bus.i_psum_vld = 1'b0;
        chk("err_drain_psum", {31'h0, o_err}, 32'h1);
        exp_mem[0] = 24'd3; exp_mem[1] = 24'd4;
        drain(2, 0);
        chk("err_sticky", {31'h0, o_err}, 32'h1);

        // reset during ACCUM, then a fresh tile shows no residue
        start_tile(2, 2);
        chk("rst_acc_errclr", {31'h0, o_err}, 32'h0);
        send(50); send(60); send(70);
        rst = 1'b0;
        tick();
        chk_reset_outputs("rst_accum");
        rst = 1'b1;
        start_tile(2, 1);
        send(1); send(2);
        exp_mem[0] = 24'd1; exp_mem[1] = 24'd2;
        drain(2, 0);

        // reset during a stalled DRAIN
        start_tile(2, 1);
        send(8); send(9);
        bus.i_rdy = 1'b0;
        tick();
        chk("stall_vld",  {31'h0, bus.o_vld}, 32'h1);
        chk("stall_data", {8'h0, bus.o_data}, 32'd8);
        tick();
        chk("stall_hold", {8'h0, bus.o_data}, 32'd8);
        rst = 1'b0;
        tick();
        chk_reset_outputs("rst_drain");
        rst = 1'b1;
        start_tile(1, 1);
        send(5);
        exp_mem[0] = 24'd5;
        drain(1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
